// File: rtl/audio_frame_capture_if.sv
// ---------------------------------------------------------------------------
// audio_frame_capture_if
// Valid/ready stereo frame port between the capture stage and the
// playback/processing path.
//   out_valid  : head frame present (driven by master)
//   out_ready  : consumer accepts the head frame (driven by slave)
//   out_left   : head-of-queue left sample, signed 16-bit
//   out_right  : head-of-queue right sample, signed 16-bit
// ---------------------------------------------------------------------------
interface audio_frame_capture_if;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_left;
  logic [15:0] out_right;

  modport master (
    output out_valid,
    output out_left,
    output out_right,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_left,
    input  out_right,
    output out_ready
  );
endinterface

// File: rtl/audio_frame_capture.sv
// ---------------------------------------------------------------------------
// audio_frame_capture
// Captures one left and one right 16-bit sample per LRCK period from the I2S
// deserializer, applies a 4-bit volume shift, and queues completed stereo
// frames in a small FIFO presented on a valid/ready port.
//
// Parameters:
//   FIFO_DEPTH     stereo frames buffered (power of two, 2..64)
//   CAPTURE_DELAY  AUD_XCK cycles from detected LRCK edge to sample latch (1..8)
// Ports:
//   AUD_XCK     clock for all logic
//   reset_n     synchronous active-low reset
//   AUD_LRCK    word clock, asynchronous, synchronized here
//   audiodata   parallel signed sample word
//   voi         volume, 0 = mute, 15 = unity
//   frame       valid/ready frame port (master side)
//   fifo_level  frames currently stored
//   overflow    sticky: a frame was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module audio_frame_capture #(
  parameter int FIFO_DEPTH    = 8,
  parameter int CAPTURE_DELAY = 4
) (
  input  logic                          AUD_XCK,
  input  logic                          reset_n,
  input  logic                          AUD_LRCK,
  input  logic [15:0]                   audiodata,
  input  logic [3:0]                    voi,
  audio_frame_capture_if.master         frame,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE
  } state_e;

  // ---------------- LRCK synchronizer and edge detect ----------------
  logic lrck_meta_q, lrck_sync_q, lrck_prev_q;
  logic lrck_edge;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge AUD_XCK) begin
    if (!reset_n) begin
      lrck_meta_q <= 1'b0;
      lrck_sync_q <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      lrck_meta_q <= AUD_LRCK;
      lrck_sync_q <= lrck_meta_q;
      lrck_prev_q <= lrck_sync_q;
    end
  end

  assign lrck_edge = lrck_sync_q ^ lrck_prev_q;

  // ---------------- capture FSM ----------------
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_left_q, is_left_d;
  logic            capture;

  always_ff @(posedge AUD_XCK) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_left_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_left_q <= is_left_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_left_d = is_left_q;
    capture   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Edges arriving in WAIT/CAPTURE are ignored; only IDLE looks.
        if (lrck_edge) begin
          is_left_d = lrck_sync_q;  // rising edge closes the left word
          cnt_d     = CW'(CAPTURE_DELAY - 1);
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: begin
        capture = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- volume scaling ----------------
  logic signed [15:0] sample_s;
  logic        [15:0] scaled;
  logic        [3:0]  shamt;

  always_comb begin
    sample_s = audiodata;
    shamt    = 4'd15 - voi;
    scaled   = (voi == 4'd0) ? 16'h0000 : 16'(sample_s >>> shamt);
  end

  // ---------------- left holding register ----------------
  logic [15:0] left_q;
  logic        have_left_q;
  logic        push;

  always_ff @(posedge AUD_XCK) begin
    if (!reset_n) begin
      left_q      <= '0;
      have_left_q <= 1'b0;
    end else if (capture) begin
      if (is_left_q) begin
        left_q      <= scaled;   // a second left overwrites the held one
        have_left_q <= 1'b1;
      end else begin
        have_left_q <= 1'b0;     // right consumes (or discards as orphan)
      end
    end
  end

  assign push = capture & ~is_left_q & have_left_q;

  // ---------------- frame FIFO ----------------
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q;
  logic          valid, full, pop, wr_en;
  logic [31:0]   head;

  assign valid = (count_q != '0);
  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop   = valid & frame.out_ready;
  // When full, a push only lands if the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  always_comb begin
    count_d = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge AUD_XCK) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because the outputs are gated by valid.
  always_ff @(posedge AUD_XCK) begin
    if (wr_en) mem[wr_ptr_q] <= {left_q, scaled};
  end

  assign head            = mem[rd_ptr_q];
  assign frame.out_valid = valid;
  assign frame.out_left  = valid ? head[31:16] : 16'h0000;
  assign frame.out_right = valid ? head[15:0]  : 16'h0000;
  assign fifo_level      = count_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_audio_frame_capture.sv
// ---------------------------------------------------------------------------
// tb_audio_frame_capture
// Directed bench: a table of scaling vectors plus hand-written sequences for
// capture latency, FIFO overflow / full push+pop, and reset mid-capture.
// ---------------------------------------------------------------------------
module tb_audio_frame_capture;

  localparam int FIFO_DEPTH    = 8;
  localparam int CAPTURE_DELAY = 4;
  localparam int HALF          = 12;  // AUD_XCK cycles per LRCK half period

  logic        clk;
  logic        reset_n;
  logic        lrck;
  logic [15:0] audiodata;
  logic [3:0]  voi;
  logic [3:0]  fifo_level;
  logic        overflow;

  audio_frame_capture_if fr ();

  audio_frame_capture #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .CAPTURE_DELAY (CAPTURE_DELAY)
  ) dut (
    .AUD_XCK    (clk),
    .reset_n    (reset_n),
    .AUD_LRCK   (lrck),
    .audiodata  (audiodata),
    .voi        (voi),
    .frame      (fr.master),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one LRCK half period; returns aligned to a negedge.
  task automatic send_half(input logic level, input logic [15:0] data);
    @(negedge clk);
    lrck      = level;
    audiodata = data;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_half(1'b1, l);
    send_half(1'b0, r);
  endtask

  task automatic pop_one();
    fr.out_ready = 1'b1;
    @(negedge clk);
    fr.out_ready = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  voi;
    logic [15:0] l_in;
    logic [15:0] r_in;
    logic [15:0] l_exp;
    logic [15:0] r_exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          n;
    bit          found;
    logic [15:0] exp_l;
    logic [15:0] exp_r;

    vecs[0] = '{4'd15, 16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
    vecs[1] = '{4'd14, 16'h8000, 16'h7FFE, 16'hC000, 16'h3FFF};
    vecs[2] = '{4'd0,  16'h8000, 16'h7FFE, 16'h0000, 16'h0000};
    vecs[3] = '{4'd1,  16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[4] = '{4'd8,  16'h7FFF, 16'h8000, 16'h00FF, 16'hFF00};
    vecs[5] = '{4'd15, 16'h0001, 16'hFFFE, 16'h0001, 16'hFFFE};

    reset_n      = 1'b0;
    lrck         = 1'b0;
    audiodata    = 16'h0000;
    voi          = 4'd15;
    fr.out_ready = 1'b0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",    32'(fr.out_valid), 32'd0);
    check("rst_left",     32'(fr.out_left),  32'd0);
    check("rst_right",    32'(fr.out_right), 32'd0);
    check("rst_level",    32'(fifo_level),   32'd0);
    check("rst_overflow", 32'(overflow),     32'd0);
    reset_n = 1'b1;

    // ---- first frame with latency measurement ----
    // Edge 1 is the first clock to sample the new LRCK level; the latch
    // lands 3 + CAPTURE_DELAY edges after that one.
    repeat (2) @(negedge clk);
    lrck = 1'b1; audiodata = 16'h1234;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!found && dut.left_q == 16'h1234) begin n = i; found = 1'b1; end
    end
    check("left_latch_edge", 32'(n), 32'(CAPTURE_DELAY + 4));

    @(negedge clk);
    lrck = 1'b0; audiodata = 16'hABCD;
    n = 0; found = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (!found && fr.out_valid) begin n = i; found = 1'b1; end
    end
    check("valid_edge", 32'(n), 32'(CAPTURE_DELAY + 4));
    @(negedge clk);
    check("f1_valid", 32'(fr.out_valid), 32'd1);
    check("f1_left",  32'(fr.out_left),  32'h1234);
    check("f1_right", 32'(fr.out_right), 32'hABCD);
    check("f1_level", 32'(fifo_level),   32'd1);
    pop_one();
    check("f1_popped", 32'(fifo_level), 32'd0);

    // ---- scaling table ----
    for (int i = 0; i < 6; i++) begin
      voi = vecs[i].voi;
      send_frame(vecs[i].l_in, vecs[i].r_in);
      check($sformatf("vec%0d_valid", i), 32'(fr.out_valid), 32'd1);
      check($sformatf("vec%0d_left", i),  32'(fr.out_left),  32'(vecs[i].l_exp));
      check($sformatf("vec%0d_right", i), 32'(fr.out_right), 32'(vecs[i].r_exp));
      pop_one();
      check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'd0);
    end

    // ---- overflow: 10 frames into a depth-8 FIFO ----
    voi = 4'd15;
    for (int i = 0; i < 10; i++)
      send_frame(16'h0100 + 16'(i), 16'h0200 + 16'(i));
    check("ovf_level",    32'(fifo_level),   32'd8);
    check("ovf_flag",     32'(overflow),     32'd1);
    check("ovf_head_l",   32'(fr.out_left),  32'h0100);
    check("ovf_head_r",   32'(fr.out_right), 32'h0200);

    // ---- full: pop in the same cycle as the push ----
    send_half(1'b1, 16'h010A);
    @(negedge clk);
    lrck = 1'b0; audiodata = 16'h020A;
    repeat (CAPTURE_DELAY + 3) @(posedge clk);
    @(negedge clk);
    fr.out_ready = 1'b1;   // covers the push edge CAPTURE_DELAY+4
    @(negedge clk);
    fr.out_ready = 1'b0;
    check("full_pp_level", 32'(fifo_level),   32'd8);
    check("full_pp_ovf",   32'(overflow),     32'd1);
    check("full_pp_head",  32'(fr.out_left),  32'h0101);
    repeat (HALF) @(negedge clk);

    // ---- drain in order: frames 1..7 then the late frame 10 ----
    fr.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_l = (k < 7) ? 16'h0101 + 16'(k) : 16'h010A;
      exp_r = (k < 7) ? 16'h0201 + 16'(k) : 16'h020A;
      check($sformatf("drain%0d_left", k),  32'(fr.out_left),  32'(exp_l));
      check($sformatf("drain%0d_right", k), 32'(fr.out_right), 32'(exp_r));
      @(negedge clk);
    end
    fr.out_ready = 1'b0;
    check("drain_empty", 32'(fr.out_valid), 32'd0);
    check("drain_level", 32'(fifo_level),   32'd0);

    // ---- reset during WAIT after a left edge ----
    send_frame(16'h5555, 16'h6666);
    check("pre_rst_level", 32'(fifo_level), 32'd1);
    @(negedge clk);
    lrck = 1'b1; audiodata = 16'h7777;
    repeat (5) @(posedge clk);     // FSM is in WAIT here
    @(negedge clk);
    reset_n = 1'b0;
    lrck    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_rst_valid",    32'(fr.out_valid), 32'd0);
    check("mid_rst_left",     32'(fr.out_left),  32'd0);
    check("mid_rst_right",    32'(fr.out_right), 32'd0);
    check("mid_rst_level",    32'(fifo_level),   32'd0);
    check("mid_rst_overflow", 32'(overflow),     32'd0);
    check("mid_rst_haveleft", 32'(dut.have_left_q), 32'd0);
    repeat (HALF) @(negedge clk);
    check("no_capture_held", 32'(dut.left_q),    32'd0);
    check("no_capture_push", 32'(fr.out_valid),  32'd0);

    // First frame after reset comes from the next left/right pair.
    send_frame(16'h2468, 16'h1357);
    check("post_rst_level", 32'(fifo_level),   32'd1);
    check("post_rst_left",  32'(fr.out_left),  32'h2468);
    check("post_rst_right", 32'(fr.out_right), 32'h1357);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
